// File: rtl/basemul_host_ctrl.sv
// basemul_host_ctrl: host sequencer that loads engine RAM A/B, kicks the engine, waits for done and drains RAM C.
// Ports: clk/reset (async active-high); start/busy pass control; src_* upstream pair stream;
// wr_* RAM A/B write port; full_out/cal_en/eng_done engine handshake; readout/rd_addr/rd_data
// RAM C read port; snk_* downstream result stream; err sticky timeout flag.
// Optional: define BASEMUL_HOST_TIMEOUT_EN to enable the WAIT_DONE timeout (err otherwise tied 0).
module basemul_host_ctrl #(
  parameter int DEPTH   = 8,
  parameter int CW      = 12,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [CW-1:0]    src_a,
  input  logic [CW-1:0]    src_b,
  output logic             wr_en,
  output logic [DEPTH-1:0] wr_addr,
  output logic [CW-1:0]    wr_a,
  output logic [CW-1:0]    wr_b,
  output logic             full_out,
  output logic             cal_en,
  input  logic             eng_done,
  output logic             readout,
  output logic [DEPTH-1:0] rd_addr,
  input  logic [CW-1:0]    rd_data,
  output logic             snk_valid,
  input  logic             snk_ready,
  output logic [CW-1:0]    snk_data,
  output logic             snk_last,
  output logic             err
);
  localparam int N = 1 << DEPTH;
  typedef enum logic [2:0] {IDLE, LOAD, FULL, CAL, WAIT_DONE, DRAIN, FIN} state_t;
  state_t           state_q, state_d;
  logic [DEPTH-1:0] wcnt_q, icnt_q;
  logic [DEPTH:0]   rcnt_q;
  logic             seen_low_q, inflight_q, wptr_q, rptr_q;
  logic [1:0]       cnt_q;
  logic [CW-1:0]    mem_q [2];
  logic             pop, done_edge, timeout;
  // eng_done may still be high from the previous pass, so only a rise after a low sample counts.
  assign done_edge = (state_q == WAIT_DONE) && seen_low_q && eng_done;
`ifdef BASEMUL_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] tcnt_q;
  logic          err_q;
  assign timeout = (state_q == WAIT_DONE) && !done_edge && (tcnt_q == TW'(TIMEOUT - 1));
  assign err = err_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= (state_q == WAIT_DONE) ? tcnt_q + 1'b1 : '0;
      err_q  <= err_q | timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err = 1'b0;
`endif
  always_comb begin
    busy      = state_q != IDLE;
    src_ready = state_q == LOAD;
    wr_en     = src_ready && src_valid;
    wr_addr   = wr_en ? wcnt_q : '0;
    wr_a      = wr_en ? src_a : '0;
    wr_b      = wr_en ? src_b : '0;
    full_out  = (state_q == FULL) || (state_q == CAL);
    cal_en    = state_q == CAL;
    snk_valid = cnt_q != 2'd0;
    snk_data  = snk_valid ? mem_q[rptr_q] : '0;
    snk_last  = snk_valid && (icnt_q == DEPTH'(N - 1));
    pop       = snk_valid && snk_ready;
    // A same-cycle pop frees a slot, which is what sustains one coefficient per cycle.
    readout   = (state_q == DRAIN) && !rcnt_q[DEPTH] &&
                ((3'(cnt_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
    rd_addr   = readout ? rcnt_q[DEPTH-1:0] : '0;
    state_d   = state_q;
    case (state_q)
      IDLE:      state_d = start ? LOAD : IDLE;
      LOAD:      state_d = (wr_en && wcnt_q == DEPTH'(N - 1)) ? FULL : LOAD;
      FULL:      state_d = CAL;
      CAL:       state_d = WAIT_DONE;
      WAIT_DONE: state_d = done_edge ? DRAIN : (timeout ? IDLE : WAIT_DONE);
      DRAIN:     state_d = (pop && snk_last) ? FIN : DRAIN;
      FIN:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      icnt_q     <= '0;
      seen_low_q <= 1'b0;
      inflight_q <= 1'b0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      cnt_q      <= '0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= (state_q == IDLE) ? '0 : (wr_en && wcnt_q != DEPTH'(N - 1)) ? wcnt_q + 1'b1 : wcnt_q;
      rcnt_q     <= (state_q == DRAIN) ? rcnt_q + {{DEPTH{1'b0}}, readout} : '0;
      icnt_q     <= (state_q == DRAIN) ? icnt_q + {{(DEPTH-1){1'b0}}, pop} : '0;
      seen_low_q <= (state_q == WAIT_DONE) && (seen_low_q || !eng_done);
      inflight_q <= readout;
      if (inflight_q) mem_q[wptr_q] <= rd_data;
      wptr_q     <= wptr_q ^ inflight_q;
      rptr_q     <= rptr_q ^ pop;
      cnt_q      <= cnt_q + 2'(inflight_q) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_basemul_host_ctrl.sv
// tb_basemul_host_ctrl: directed self-checking bench for basemul_host_ctrl with a behavioural engine RAM model.
module tb_basemul_host_ctrl;
  localparam int DEPTH = 8, CW = 12, N = 256;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, src_valid = 1'b0, eng_done = 1'b0, snk_ready = 1'b0;
  logic [CW-1:0] src_a = '0, src_b = '0, rd_data;
  logic busy, src_ready, wr_en, full_out, cal_en, readout, snk_valid, snk_last, err;
  logic [DEPTH-1:0] wr_addr, rd_addr;
  logic [CW-1:0] wr_a, wr_b, snk_data;
  logic [CW-1:0] ram_a [N], ram_b [N], ram_c [N];
  int n_chk = 0, n_pass = 0;
  int n_wr, n_full, n_cal, n_rd, n_pop, bad_wr, bad_rd, bad_data, bad_last, bad_stable, bad_occ;
  int first_full_t, cal_t, first_rd_t, last_wr_t, last_pop_t, end_t, err_end, out_or;
  bit seen, prev_stall;
  logic [CW-1:0] prev_data;
  always #5 clk = ~clk;
  basemul_host_ctrl #(.DEPTH(DEPTH), .CW(CW), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .src_valid(src_valid), .src_ready(src_ready), .src_a(src_a), .src_b(src_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
    .full_out(full_out), .cal_en(cal_en), .eng_done(eng_done),
    .readout(readout), .rd_addr(rd_addr), .rd_data(rd_data),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data), .snk_last(snk_last),
    .err(err)
  );
  // Engine model: RAM C = a + 3*b, computed when cal_en fires; RAM C read has one cycle latency.
  always @(posedge clk) begin
    if (wr_en) begin
      ram_a[wr_addr] <= wr_a;
      ram_b[wr_addr] <= wr_b;
    end
    if (cal_en) for (int i = 0; i < N; i++) ram_c[i] <= CW'(ram_a[i] + 3 * ram_b[i]);
    rd_data <= ram_c[rd_addr];
  end
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic int outs_or();
    return int'(|{busy, src_ready, wr_en, wr_addr, wr_a, wr_b, full_out, cal_en, readout,
                  rd_addr, snk_valid, snk_data, snk_last, err});
  endfunction
  // dmode: 0 done 300 cycles after cal_en, 1 stale done, 2 done never rises. rst_at>0 resets after that many writes.
  task automatic run_pass(input bit gap, input bit bp, input int dmode, input int rst_at);
    n_wr = 0; n_full = 0; n_cal = 0; n_rd = 0; n_pop = 0;
    bad_wr = 0; bad_rd = 0; bad_data = 0; bad_last = 0; bad_stable = 0; bad_occ = 0;
    first_full_t = -1; cal_t = -1; first_rd_t = -1; last_wr_t = -1; last_pop_t = -1; end_t = -1;
    seen = 0; prev_stall = 0; prev_data = '0; err_end = 0; out_or = -1;
    for (int t = 0; t < 3000 && end_t < 0; t++) begin
      @(posedge clk); #1;
      start     = (t == 0 || t == 600);
      src_valid = gap ? (t % 4 == 0 || t % 4 == 3) : 1'b1;
      src_a     = CW'(n_wr);
      src_b     = CW'(2 * n_wr);
      snk_ready = bp ? (t % 3 == 0) : 1'b1;
      eng_done  = (dmode == 1) ? (cal_t < 0 || t < cal_t + 5 || t >= cal_t + 45)
                               : (dmode == 0 && cal_t >= 0 && t >= cal_t + 300);
      @(negedge clk);
      if (wr_en) begin
        if (int'(wr_addr) != n_wr || int'(wr_a) != n_wr || int'(wr_b) != 2 * n_wr) bad_wr++;
        n_wr++;
        last_wr_t = t;
      end
      if (full_out) begin
        n_full++;
        if (first_full_t < 0) first_full_t = t;
      end
      if (cal_en) begin
        n_cal++;
        cal_t = t;
      end
      if (readout) begin
        if (int'(rd_addr) != n_rd) bad_rd++;
        if (first_rd_t < 0) first_rd_t = t;
        n_rd++;
      end
      if (prev_stall && (!snk_valid || snk_data != prev_data)) bad_stable++;
      if (snk_valid && snk_ready) begin
        if (int'(snk_data) != (7 * n_pop) % 4096) bad_data++;
        if (snk_last != (n_pop == N - 1)) bad_last++;
        n_pop++;
        last_pop_t = t;
      end
      if (n_rd - n_pop > 2) bad_occ++;
      prev_stall = snk_valid && !snk_ready;
      prev_data  = snk_data;
      if (busy) seen = 1;
      if (seen && !busy) begin
        end_t = t;
        err_end = int'(err);
      end
      if (rst_at > 0 && n_wr == rst_at) begin
        #2 reset = 1'b1;
        #1 out_or = outs_or();
        end_t = t;
      end
    end
    start = 1'b0;
  endtask
  initial begin
    #1 check("reset_outputs", outs_or(), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    run_pass(0, 0, 0, 0);
    check("nom_end", int'(end_t >= 0), 1);
    check("nom_writes", n_wr, N);
    check("nom_wr_order", bad_wr, 0);
    check("nom_full_cycles", n_full, 2);
    check("nom_full_entry", first_full_t, last_wr_t + 1);
    check("nom_cal_pulses", n_cal, 1);
    check("nom_cal_timing", cal_t, first_full_t + 1);
    check("nom_first_readout", first_rd_t, cal_t + 301);
    check("nom_readouts", n_rd, N);
    check("nom_rd_order", bad_rd, 0);
    check("nom_pops", n_pop, N);
    check("nom_data", bad_data, 0);
    check("nom_last", bad_last, 0);
    check("nom_throughput", last_pop_t - first_rd_t, N + 1);
    check("nom_busy_drop", end_t, last_pop_t + 2);
    check("nom_occupancy", bad_occ, 0);
`ifndef BASEMUL_HOST_TIMEOUT_EN
    check("nom_err_tied", err_end, 0);
`endif
    run_pass(1, 0, 0, 0);
    check("gap_writes", n_wr, N);
    check("gap_wr_order", bad_wr, 0);
    check("gap_full_entry", first_full_t, last_wr_t + 1);
    check("gap_pops", n_pop, N);
    check("gap_data", bad_data, 0);
    run_pass(0, 1, 0, 0);
    check("bp_pops", n_pop, N);
    check("bp_readouts", n_rd, N);
    check("bp_data", bad_data, 0);
    check("bp_stable", bad_stable, 0);
    check("bp_occupancy", bad_occ, 0);
    check("bp_last", bad_last, 0);
    check("bp_busy_drop", end_t, last_pop_t + 2);
    run_pass(0, 0, 1, 0);
    check("stale_first_readout", first_rd_t, cal_t + 46);
    check("stale_pops", n_pop, N);
    check("stale_data", bad_data, 0);
    run_pass(0, 0, 0, 100);
    check("rst_outputs", out_or, 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk); #1 reset = 1'b0;
    run_pass(0, 0, 0, 0);
    check("rst_rewrites", n_wr, N);
    check("rst_wr_order", bad_wr, 0);
    check("rst_pops", n_pop, N);
`ifdef BASEMUL_HOST_TIMEOUT_EN
    run_pass(0, 0, 2, 0);
    check("to_end", end_t, cal_t + 65);
    check("to_err", err_end, 1);
    check("to_no_readout", n_rd, 0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("to_err_sticky", int'(err), 1);
    check("to_restart_busy", int'(busy), 1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
